approx_adder_arbiter: RTL and testbench

- Shares one approx_adder instance among NUM_REQ requesters using round-robin arbitration.
- Each requester uses a valid/ready handshake; results return through a single registered response port tagged with the requester ID.
- Sits between multiple arithmetic clients (e.g. address or accumulation units) and the shared adder datapath.
- At most one operation is accepted per cycle, with a fixed one-cycle latency from acceptance to response.

---
 rtl/approx_adder_arbiter_if.sv | 30 +++
 rtl/approx_adder_arbiter.sv | 148 ++++++++++++++
 tb/tb_approx_adder_arbiter.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/approx_adder_arbiter_if.sv
// Request/response bundle between the arithmetic clients and the shared adder arbiter.
// Ports: per-requester valid/ready/operands, a single tagged response port, and a drain counter.
// master = client/consumer side, slave = arbiter side.
interface approx_adder_arbiter_if #(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ-1:0][31:0] req_a;
    logic [NUM_REQ-1:0][31:0] req_b;
    logic [NUM_REQ-1:0]       req_add;

    logic                     resp_valid;
    logic                     resp_ready;
    logic [ID_WIDTH-1:0]      resp_id;
    logic [31:0]              resp_sum;
    logic                     resp_carry;
    logic [15:0]              ops_done;

    modport master (
        output req_valid, req_a, req_b, req_add, resp_ready,
        input  req_ready, resp_valid, resp_id, resp_sum, resp_carry, ops_done
    );

    modport slave (
        input  req_valid, req_a, req_b, req_add, resp_ready,
        output req_ready, resp_valid, resp_id, resp_sum, resp_carry, ops_done
    );
endinterface

// File: rtl/approx_adder_arbiter.sv
// Round-robin arbiter sharing one approximate 32-bit adder among NUM_REQ requesters.
// Latency: 1 cycle from acceptance (req_valid & req_ready) to resp_valid.
// Backpressure: a held, undrained response blocks all grants; req_ready is 0 while stalled.
//
// Ports: clk, reset (async, active-high), bus (slave modport of approx_adder_arbiter_if):
//   req_valid/req_ready/req_a/req_b/req_add per requester, resp_valid/resp_ready/resp_id/
//   resp_sum/resp_carry for the single registered result, ops_done counts drained results.
module approx_adder_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int APPROX_LV = 0,
    parameter int ID_WIDTH  = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 reset,
    approx_adder_arbiter_if.slave bus
);
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    state_e              state_q,      state_d;
    logic [ID_WIDTH-1:0] ptr_q,        ptr_d;
    logic [ID_WIDTH-1:0] resp_id_q,    resp_id_d;
    logic [31:0]         resp_sum_q,   resp_sum_d;
    logic                resp_carry_q, resp_carry_d;
    logic [15:0]         ops_done_q,   ops_done_d;

    logic                resp_vld;
    logic                can_accept;
    logic                drain;
    logic                accept;
    logic                grant_vld;
    logic [ID_WIDTH-1:0] grant_idx;
    logic [ID_WIDTH-1:0] scan_idx;
    logic [NUM_REQ-1:0]  grant_onehot;

    logic [31:0]         op_a;
    logic [31:0]         op_b;
    logic                op_add;
    logic [31:0]         add_b;
    logic [31:0]         add_sum;
    logic                add_carry;

    assign resp_vld   = (state_q == ST_FULL);
    assign can_accept = !resp_vld || bus.resp_ready;
    assign drain      = resp_vld && bus.resp_ready;

    // Rotating-priority search: first asserted request at or above ptr, wrapping.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        scan_idx  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = ID_WIDTH'((int'(ptr_q) + k) % NUM_REQ);
            if (!grant_vld && bus.req_valid[scan_idx]) begin
                grant_vld = 1'b1;
                grant_idx = scan_idx;
            end
        end
    end

    // Grants are withheld while reset is asserted so nothing looks accepted
    // during a reset the flops will discard.
    assign accept = grant_vld && can_accept && !reset;

    always_comb begin
        grant_onehot = '0;
        if (accept) begin
            grant_onehot[grant_idx] = 1'b1;
        end
    end

    assign bus.req_ready = grant_onehot;

    // Operands of the granted requester feed the single shared adder.
    assign op_a   = bus.req_a[grant_idx];
    assign op_b   = bus.req_b[grant_idx];
    assign op_add = bus.req_add[grant_idx];

    // Subtract form is a + ~b with carry-in 0 (a - b - 1); no +1 is injected.
    assign add_b = op_add ? op_b : ~op_b;

    // Shared approximate adder: low APPROX_LV bits are OR'd with no carry
    // generation, the upper bits form an exact adder with carry-in 0.
    generate
        if (APPROX_LV <= 0) begin : g_adder_exact
            assign {add_carry, add_sum} = {1'b0, op_a} + {1'b0, add_b};
        end else if (APPROX_LV >= 32) begin : g_adder_all_or
            assign add_sum   = op_a | add_b;
            assign add_carry = 1'b0;
        end else begin : g_adder_approx
            localparam int HI_W = 32 - APPROX_LV;
            logic [HI_W:0] hi_sum;
            assign hi_sum    = {1'b0, op_a[31:APPROX_LV]} + {1'b0, add_b[31:APPROX_LV]};
            assign add_sum   = {hi_sum[HI_W-1:0], op_a[APPROX_LV-1:0] | add_b[APPROX_LV-1:0]};
            assign add_carry = hi_sum[HI_W];
        end
    endgenerate

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        resp_id_d    = resp_id_q;
        resp_sum_d   = resp_sum_q;
        resp_carry_d = resp_carry_q;
        ops_done_d   = ops_done_q;

        if (drain) begin
            ops_done_d = ops_done_q + 16'd1;
            state_d    = ST_EMPTY;
        end

        // A grant in the drain cycle reloads the register, keeping it full.
        if (accept) begin
            state_d      = ST_FULL;
            resp_id_d    = grant_idx;
            resp_sum_d   = add_sum;
            resp_carry_d = add_carry;
            ptr_d        = (grant_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0
                                                                 : grant_idx + ID_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_EMPTY;
            ptr_q        <= '0;
            resp_id_q    <= '0;
            resp_sum_q   <= '0;
            resp_carry_q <= 1'b0;
            ops_done_q   <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            resp_id_q    <= resp_id_d;
            resp_sum_q   <= resp_sum_d;
            resp_carry_q <= resp_carry_d;
            ops_done_q   <= ops_done_d;
        end
    end

    assign bus.resp_valid = resp_vld;
    assign bus.resp_id    = resp_id_q;
    assign bus.resp_sum   = resp_sum_q;
    assign bus.resp_carry = resp_carry_q;
    assign bus.ops_done   = ops_done_q;
endmodule

// File: tb/tb_approx_adder_arbiter.sv
// Bench for approx_adder_arbiter: two instances (APPROX_LV=0 and 4) share one stimulus.
// Table vectors, hand sequences for round-robin/stall/reset/wrap, then a random phase
// checked every cycle against a behavioural model.
module tb_approx_adder_arbiter;
    localparam int NUM_REQ = 4;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic [NUM_REQ-1:0]       req_valid  = '0;
    logic [NUM_REQ-1:0]       req_add    = '0;
    logic [NUM_REQ-1:0][31:0] req_a      = '0;
    logic [NUM_REQ-1:0][31:0] req_b      = '0;
    logic                     resp_ready = 1'b0;

    approx_adder_arbiter_if #(.NUM_REQ(NUM_REQ)) bus0 ();
    approx_adder_arbiter_if #(.NUM_REQ(NUM_REQ)) bus4 ();

    assign bus0.req_valid  = req_valid;
    assign bus0.req_add    = req_add;
    assign bus0.req_a      = req_a;
    assign bus0.req_b      = req_b;
    assign bus0.resp_ready = resp_ready;
    assign bus4.req_valid  = req_valid;
    assign bus4.req_add    = req_add;
    assign bus4.req_a      = req_a;
    assign bus4.req_b      = req_b;
    assign bus4.resp_ready = resp_ready;

    approx_adder_arbiter #(.NUM_REQ(NUM_REQ), .APPROX_LV(0)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0.slave));
    approx_adder_arbiter #(.NUM_REQ(NUM_REQ), .APPROX_LV(4)) dut4 (
        .clk(clk), .reset(reset), .bus(bus4.slave));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Reference adder from the arithmetic rules: OR the low lv bits,
    // plain integer add of the bits above them, carry is the bit past 31.
    function automatic logic [32:0] model_add(input logic [31:0] a, input logic [31:0] b,
                                              input logic add, input int lv);
        logic [31:0]     bb;
        longint unsigned hi, lowmask, s;
        bb      = add ? b : ~b;
        hi      = (64'(a) >> lv) + (64'(bb) >> lv);
        lowmask = (64'd1 << lv) - 64'd1;
        s       = (hi << lv) | (64'(a | bb) & lowmask);
        return {1'b0, s[31:0]} | {((hi >> (32 - lv)) & 64'd1) != 0, 32'h0};
    endfunction

    // Behavioural state: the held result, the rotation pointer, the drain count.
    bit          m_valid;
    int          m_id;
    logic [31:0] m_a, m_b;
    logic        m_add;
    int          m_ptr;
    int          m_ops;
    int          last_grant;

    task automatic model_reset();
        m_valid = 0; m_id = 0; m_a = '0; m_b = '0; m_add = 1'b0;
        m_ptr = 0; m_ops = 0; last_grant = -1;
    endtask

    // Compare both DUTs against the model for the current cycle, then advance the model
    // across the coming clock edge.
    task automatic model_cycle();
        bit                 can;
        int                 g;
        int                 order[$];
        logic [NUM_REQ-1:0] exp_rdy;
        logic [32:0]        r0, r4;
        can = !m_valid || resp_ready;
        g   = -1;
        order.delete();
        for (int k = 0; k < NUM_REQ; k++) order.push_back((m_ptr + k) % NUM_REQ);
        if (can) foreach (order[i]) if (g < 0 && req_valid[order[i]]) g = order[i];
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;

        chk("req_ready_lv0", bus0.req_ready, exp_rdy);
        chk("req_ready_lv4", bus4.req_ready, exp_rdy);
        chk("resp_valid_lv0", bus0.resp_valid, m_valid);
        chk("resp_valid_lv4", bus4.resp_valid, m_valid);
        if (m_valid) begin
            r0 = model_add(m_a, m_b, m_add, 0);
            r4 = model_add(m_a, m_b, m_add, 4);
            chk("resp_id_lv0", bus0.resp_id, m_id);
            chk("resp_id_lv4", bus4.resp_id, m_id);
            chk("resp_sum_lv0", bus0.resp_sum, r0[31:0]);
            chk("resp_carry_lv0", bus0.resp_carry, r0[32]);
            chk("resp_sum_lv4", bus4.resp_sum, r4[31:0]);
            chk("resp_carry_lv4", bus4.resp_carry, r4[32]);
        end
        chk("ops_done_lv0", bus0.ops_done, m_ops);
        chk("ops_done_lv4", bus4.ops_done, m_ops);

        if (m_valid && resp_ready) begin
            m_ops   = (m_ops + 1) % 65536;
            m_valid = 0;
        end
        if (g >= 0) begin
            m_valid = 1; m_id = g;
            m_a = req_a[g]; m_b = req_b[g]; m_add = req_add[g];
            m_ptr = (g + 1) % NUM_REQ;
        end
        last_grant = g;
    endtask

    // Asserts reset mid-cycle (never on a clock edge) so the asynchronous clear is visible.
    task automatic do_reset();
        req_valid  = '1;
        resp_ready = 1'b1;
        reset      = 1'b1;
        #1;
        chk("rst_req_ready_lv0", bus0.req_ready, 0);
        chk("rst_req_ready_lv4", bus4.req_ready, 0);
        chk("rst_resp_valid_lv0", bus0.resp_valid, 0);
        chk("rst_resp_valid_lv4", bus4.resp_valid, 0);
        chk("rst_resp_id", bus0.resp_id, 0);
        chk("rst_resp_sum", bus0.resp_sum, 0);
        chk("rst_resp_carry", bus0.resp_carry, 0);
        chk("rst_ops_done_lv0", bus0.ops_done, 0);
        chk("rst_ops_done_lv4", bus4.ops_done, 0);
        @(posedge clk); #1;
        chk("rst_hold_resp_valid", bus0.resp_valid, 0);
        req_valid = '0;
        reset     = 1'b0;
        #1;
        model_reset();
    endtask

    typedef struct {
        int          id;
        logic [31:0] a;
        logic [31:0] b;
        logic        add;
        logic [31:0] s0;
        logic        c0;
        logic [31:0] s4;
        logic        c4;
    } vec_t;

    vec_t vecs[6];

    localparam int RR_ORDER[5] = '{0, 1, 2, 3, 0};

    initial begin
        vecs[0] = '{0, 32'd5,          32'd7,          1'b1, 32'd12,         1'b0, 32'd7,          1'b0};
        vecs[1] = '{1, 32'd10,         32'd3,          1'b0, 32'd6,          1'b1, 32'hFFFF_FFFE,  1'b0};
        vecs[2] = '{2, 32'hFFFF_FFFF,  32'd1,          1'b1, 32'd0,          1'b1, 32'hFFFF_FFFF,  1'b0};
        vecs[3] = '{3, 32'h0000_000F,  32'h0000_0001,  1'b1, 32'h10,         1'b0, 32'h0000_000F,  1'b0};
        vecs[4] = '{0, 32'h8000_0000,  32'h8000_0000,  1'b1, 32'd0,          1'b1, 32'd0,          1'b1};
        vecs[5] = '{1, 32'd3,          32'd3,          1'b0, 32'hFFFF_FFFF,  1'b0, 32'hFFFF_FFFF,  1'b0};

        #3;
        do_reset();

        // Single-requester vectors: grant, one-cycle result, drain.
        foreach (vecs[i]) begin
            req_valid              = '0;
            req_valid[vecs[i].id]  = 1'b1;
            req_a[vecs[i].id]      = vecs[i].a;
            req_b[vecs[i].id]      = vecs[i].b;
            req_add[vecs[i].id]    = vecs[i].add;
            resp_ready             = 1'b1;
            #1;
            chk("tbl_ready", bus0.req_ready, 64'd1 << vecs[i].id);
            model_cycle();
            @(posedge clk); #1;
            req_valid = '0;
            #1;
            chk("tbl_id", bus0.resp_id, vecs[i].id);
            chk("tbl_sum_lv0", bus0.resp_sum, vecs[i].s0);
            chk("tbl_carry_lv0", bus0.resp_carry, vecs[i].c0);
            chk("tbl_sum_lv4", bus4.resp_sum, vecs[i].s4);
            chk("tbl_carry_lv4", bus4.resp_carry, vecs[i].c4);
            model_cycle();
            @(posedge clk); #1;
        end

        // Round-robin with all four requesters held, then a 3-cycle stall.
        do_reset();
        for (int r = 0; r < NUM_REQ; r++) begin
            req_a[r] = 32'(r * 100 + 1); req_b[r] = 32'(r + 1); req_add[r] = 1'b1;
        end
        req_valid  = '1;
        resp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("rr_grant", bus0.req_ready, 64'd1 << RR_ORDER[i]);
            model_cycle();
            @(posedge clk); #1;
        end
        resp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_ops_done", bus0.ops_done, 4);
            chk("stall_ready", bus0.req_ready, 0);
            model_cycle();
            @(posedge clk); #1;
        end
        resp_ready = 1'b1;
        #1;
        chk("unstall_grant", bus0.req_ready, 4'b0010);
        model_cycle();
        @(posedge clk); #1;
        req_valid = '0;
        for (int i = 0; i < 2; i++) begin
            #1; model_cycle(); @(posedge clk); #1;
        end

        // Reset with a result held and five completions counted.
        do_reset();
        req_valid  = 4'b0001;
        req_a[0]   = 32'd40; req_b[0] = 32'd2; req_add[0] = 1'b1;
        resp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1; model_cycle(); @(posedge clk); #1;
        end
        chk("pre_reset_ops_done", bus0.ops_done, 5);
        chk("pre_reset_valid", bus0.resp_valid, 1);
        do_reset();
        #1; model_cycle(); @(posedge clk); #1;
        #1; model_cycle(); @(posedge clk); #1;

        // Counter wrap: 65535 drains then one more.
        req_valid  = '1;
        resp_ready = 1'b1;
        for (int i = 0; i < 65536; i++) @(posedge clk);
        #1;
        chk("ops_done_ffff_lv0", bus0.ops_done, 16'hFFFF);
        chk("ops_done_ffff_lv4", bus4.ops_done, 16'hFFFF);
        @(posedge clk); #1;
        chk("ops_done_wrap_lv0", bus0.ops_done, 0);
        chk("ops_done_wrap_lv4", bus4.ops_done, 0);
        chk("wrap_valid", bus0.resp_valid, 1);

        // Random traffic; requesters hold valid and operands until granted.
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            if (last_grant >= 0) req_valid[last_grant] = 1'b0;
            for (int r = 0; r < NUM_REQ; r++) begin
                if (!req_valid[r] && $urandom_range(0, 2) == 0) begin
                    req_valid[r] = 1'b1;
                    req_a[r]     = $urandom;
                    case ($urandom_range(0, 3))
                        0:       req_b[r] = ~req_a[r];
                        1:       req_b[r] = req_a[r];
                        default: req_b[r] = $urandom;
                    endcase
                    req_add[r] = 1'($urandom_range(0, 1));
                end
            end
            resp_ready = ($urandom_range(0, 3) != 0);
            #1;
            model_cycle();
            @(posedge clk); #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
